instruction_sequencer: RTL and testbench

- Program buffer and issue sequencer that drives the 25-bit instruction word into control_unit.
- Host loads a program of up to DEPTH instructions, then pulses start.
- Block issues one instruction per non-stalled cycle, inserts NOPs (all-zero word) while stalled or idle, and signals completion.
- Sits between the host/testbench loader and control_unit.

---
 rtl/tpu_pkg.sv | 28 ++
 rtl/instr_mem.sv | 35 +++
 rtl/instruction_sequencer.sv | 128 ++++++++++++
 tb/tb_instruction_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction width, NOP word, sequencer states and
// the instruction field layout decoded by control_unit.
package tpu_pkg;

  localparam int unsigned INSTR_W = 25;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  // Instruction field positions.
  localparam int unsigned LrIsBackwardBit   = 24;
  localparam int unsigned NnStartBit        = 23;
  localparam int unsigned AcceptWBit        = 22;
  localparam int unsigned SwitchBit         = 21;
  localparam int unsigned ActDatapathMsb    = 20;
  localparam int unsigned ActDatapathLsb    = 19;
  localparam int unsigned LoadSelMsb        = 18;
  localparam int unsigned LoadSelLsb        = 17;
  localparam int unsigned AddressBit        = 16;
  localparam int unsigned DataMsb           = 15;
  localparam int unsigned DataLsb           = 0;

endpackage

// File: rtl/instr_mem.sv
// Program buffer: one write port, one registered read port whose output
// register can be cleared to the NOP word.
module instr_mem #(
  parameter int unsigned INSTR_W = 25,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  input  logic               clr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // clr has priority so a cleared cycle always presents a NOP.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Program buffer plus issue FSM feeding control_unit one word per
// non-stalled cycle, with NOPs while stalled or idle.
module instruction_sequencer #(
  parameter int unsigned INSTR_W = tpu_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done
);

  import tpu_pkg::*;

  localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   len_clamped;
  logic          valid_q;
  logic          done_q;
  logic          last;
  logic          issue;
  logic          mem_we;
  logic          mem_clr;

  assign len_clamped = (prog_len > DepthLen) ? DepthLen : prog_len;
  assign last        = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, PC and length logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len_clamped;
          pc_d    = '0;
          state_d = (len_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          pc_d    = '0;
          state_d = StDone;
        end else if (!stall) begin
          if (last) begin
            pc_d    = '0;
            state_d = StDone;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    issue   = (state_q == StRun) && !abort && !stall;
    mem_we  = prog_we && (state_q != StRun);
    mem_clr = rst || !issue;
    busy    = (state_q == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      len_q   <= len_d;
      valid_q <= issue;
      // Registered so done lands the cycle after the last issued word.
      done_q  <= (state_q == StDone);
    end
  end

  instr_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_instr_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (issue),
    .raddr (pc_q),
    .clr   (mem_clr),
    .rdata (instruction)
  );

  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer.
module tb_instruction_sequencer;

  localparam int unsigned INSTR_W = 25;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned AW      = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               prog_we = 1'b0;
  logic [AW-1:0]      prog_addr = '0;
  logic [INSTR_W-1:0] prog_data = '0;
  logic [AW:0]        prog_len = '0;
  logic               start = 1'b0;
  logic               stall = 1'b0;
  logic               abort = 1'b0;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               done;

  logic [INSTR_W-1:0] model [DEPTH];
  int errors = 0;
  int checks = 0;

  instruction_sequencer #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .stall       (stall),
    .abort       (abort),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [INSTR_W-1:0] data);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
    model[addr] = data;
  endtask

  task automatic chk_out(input string tag, input logic [INSTR_W-1:0] ins, input logic v,
                         input int p, input logic b, input logic d);
    chk({tag, ".instr"}, 32'(instruction), 32'(ins));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Start a run and collect issued words until done, bounded by a cycle budget.
  task automatic run_prog(input logic [AW:0] len, input int expn, input string tag);
    int   n = 0;
    int   ndone = 0;
    logic prev_valid = 1'b0;
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    prog_len = '0;
    for (int c = 0; c < 300 && ndone == 0; c++) begin
      tick();
      if (done) begin
        ndone++;
        chk({tag, ".done_after_last"}, 32'(prev_valid), (expn > 0) ? 32'd1 : 32'd0);
        chk({tag, ".valid_at_done"}, 32'(instr_valid), 32'd0);
        chk({tag, ".pc_at_done"}, 32'(pc), 32'd0);
      end
      if (instr_valid) begin
        chk($sformatf("%s.word%0d", tag, n), 32'(instruction), 32'(model[n % DEPTH]));
        n++;
      end
      prev_valid = instr_valid;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) ndone++;
    end
    chk({tag, ".count"}, 32'(n), 32'(expn));
    chk({tag, ".ndone"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    int runs;

    // Reset.
    rst = 1'b1;
    tick();
    tick();
    chk_out("reset", '0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic run.
    write_word(0, 25'h0820001);
    write_word(1, 25'h0440002);
    write_word(2, 25'h1000003);
    prog_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("basic.s0", '0, 1'b0, 0, 1'b1, 1'b0);
    tick();
    chk_out("basic.w0", 25'h0820001, 1'b1, 1, 1'b1, 1'b0);
    tick();
    chk_out("basic.w1", 25'h0440002, 1'b1, 2, 1'b1, 1'b0);
    tick();
    chk_out("basic.w2", 25'h1000003, 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk_out("basic.done", '0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    chk_out("basic.idle", '0, 1'b0, 0, 1'b0, 1'b0);

    // Stall for two cycles after the first word; start during RUN is ignored.
    runs = 0;
    prog_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    runs += int'(busy);
    tick();
    runs += int'(busy);
    chk_out("stall.w0", 25'h0820001, 1'b1, 1, 1'b1, 1'b0);
    stall = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    runs += int'(busy);
    chk_out("stall.n0", '0, 1'b0, 1, 1'b1, 1'b0);
    tick();
    runs += int'(busy);
    chk_out("stall.n1", '0, 1'b0, 1, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    runs += int'(busy);
    chk_out("stall.w1", 25'h0440002, 1'b1, 2, 1'b1, 1'b0);
    tick();
    runs += int'(busy);
    chk_out("stall.w2", 25'h1000003, 1'b1, 0, 1'b0, 1'b0);
    chk("stall.run_cycles", 32'(runs), 32'd5);
    tick();
    chk_out("stall.done", '0, 1'b0, 0, 1'b0, 1'b1);
    tick();

    // Zero length: done two cycles after start, never valid.
    prog_len = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("zero.s0", '0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_out("zero.done", '0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    chk_out("zero.idle", '0, 1'b0, 0, 1'b0, 1'b0);

    // Full depth and oversize length.
    for (int i = 0; i < DEPTH; i++) begin
      write_word(i, INSTR_W'(i * 32'h0004_1041) ^ 25'h00A55A5);
    end
    run_prog(7'd64, 64, "full64");
    run_prog(7'd100, 64, "full100");

    // Abort with a protected write during RUN.
    write_word(0, 25'h0820001);
    write_word(1, 25'h0440002);
    write_word(2, 25'h1000003);
    prog_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("abort.w0", 25'h0820001, 1'b1, 1, 1'b1, 1'b0);
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = 25'h1FFFFFF;
    tick();
    prog_we   = 1'b0;
    chk_out("abort.w1", 25'h0440002, 1'b1, 2, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("abort.cut", '0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_out("abort.done", '0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    run_prog(7'd3, 3, "rerun");

    // Reset in the middle of a run: no done pulse.
    prog_len = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("rstrun.w0", 25'h0820001, 1'b1, 1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rstrun.r0", '0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_out("rstrun.r1", '0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk_out("rstrun.r2", '0, 1'b0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
